led_matrix_pwm: RTL and testbench

LED_MATRIX_PWM -- requirements
Module: led_matrix_pwm

---
 rtl/led_matrix_pwm_if.sv | 29 ++
 rtl/led_matrix_pwm.sv | 216 +++++++++++++++++++++
 tb/tb_led_matrix_pwm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_pwm_if.sv
// Pixel write port and front/back swap handshake for the LED matrix scanner.
// The master side writes pixels and requests swaps; the scanner acknowledges.
interface led_matrix_pwm_if #(
  parameter int N_BITS   = 3,
  parameter int M_BITS   = 3,
  parameter int PWM_BITS = 2
) ();
  logic                       wr_en;
  logic [N_BITS+M_BITS-1:0]   wr_addr;
  logic [PWM_BITS-1:0]        wr_data;
  logic                       swap_req;
  logic                       swap_ack;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output swap_req,
    input  swap_ack
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  swap_req,
    output swap_ack
  );
endinterface

// File: rtl/led_matrix_pwm.sv
// Row-scanned LED matrix driver with per-pixel PWM and double-buffered pixels.
// Each row: BLANK_CYCLES dark clocks, then (2^PWM_BITS-1) PWM steps of P clocks.
module led_matrix_pwm #(
  parameter int LEDS_N          = 4,
  parameter int LEDS_M          = 4,
  parameter int N_BITS          = 3,
  parameter int M_BITS          = 3,
  parameter int PWM_BITS        = 2,
  parameter int LED_PERIOD_BITS = 4,
  parameter int BLANK_CYCLES    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [LED_PERIOD_BITS-1:0] led_period,
  led_matrix_pwm_if.slave            bus,
  output logic [LEDS_N-1:0]          n_en,
  output logic [LEDS_M-1:0]          m_en,
  output logic                       done_tick
);

  localparam int NPIX  = LEDS_N * LEDS_M;
  localparam int BUF_W = NPIX * PWM_BITS;
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BLK_W-1:0]    BLANK_LAST = BLK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [PWM_BITS-1:0] STEP_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [N_BITS-1:0]   ROW_LAST   = N_BITS'(LEDS_N - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t                     state_reg, state_next;
  logic [N_BITS-1:0]          row_reg, row_next;
  logic [BLK_W-1:0]           blank_reg, blank_next;
  logic [PWM_BITS-1:0]        step_reg, step_next;
  logic [LED_PERIOD_BITS-1:0] tick_reg, tick_next;
  logic [LED_PERIOD_BITS-1:0] period_reg, period_next;
  logic                       sel_reg, sel_next;
  logic                       pend_reg, pend_next;
  logic [LEDS_N-1:0]          n_en_reg, n_en_next;
  logic [LEDS_M-1:0]          m_en_reg, m_en_next;
  logic                       done_reg, done_next;
  logic                       ack_reg, ack_next;
  logic [BUF_W-1:0]           buf0_reg, buf1_reg;

  logic [LED_PERIOD_BITS-1:0] period_in;
  logic                       row_start;
  logic [N_BITS-1:0]          row_start_idx;
  logic                       swap_fire;
  logic [BUF_W-1:0]           front;
  logic [NPIX-1:0]            wr_hit;
  logic [N_BITS-1:0]          wr_row;
  logic [M_BITS-1:0]          wr_col;

  // A zero period would stall the step counter, so it is treated as one clock.
  assign period_in = (led_period == '0) ? LED_PERIOD_BITS'(1) : led_period;

  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    blank_next    = blank_reg;
    step_next     = step_reg;
    tick_next     = tick_reg;
    period_next   = period_reg;
    row_start     = 1'b0;
    row_start_idx = row_reg;
    case (state_reg)
      IDLE: begin
        if (en) begin
          row_start     = 1'b1;
          row_start_idx = '0;
          period_next   = period_in;
        end
      end
      BLANK: begin
        if (blank_reg == BLANK_LAST) begin
          state_next = ON;
          step_next  = '0;
          tick_next  = '0;
        end else begin
          blank_next = blank_reg + BLK_W'(1);
        end
      end
      ON: begin
        if (tick_reg == period_reg - LED_PERIOD_BITS'(1)) begin
          tick_next = '0;
          if (step_reg == STEP_LAST) begin
            row_start = 1'b1;
            if (row_reg == ROW_LAST) begin
              row_start_idx = '0;
              period_next   = period_in;
            end else begin
              row_start_idx = row_reg + N_BITS'(1);
            end
          end else begin
            step_next = step_reg + PWM_BITS'(1);
          end
        end else begin
          tick_next = tick_reg + LED_PERIOD_BITS'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (row_start) begin
      row_next   = row_start_idx;
      blank_next = '0;
      step_next  = '0;
      tick_next  = '0;
      state_next = (BLANK_CYCLES == 0) ? ON : BLANK;
    end

    // Dropping enable always wins and never latches a new period.
    if (!en) begin
      state_next  = IDLE;
      period_next = period_reg;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_comb begin
    done_next = (state_next == ON) && (row_next == ROW_LAST) &&
                (step_next == STEP_LAST) &&
                (tick_next == period_next - LED_PERIOD_BITS'(1));
    swap_fire = done_next && (pend_reg || bus.swap_req);
    ack_next  = swap_fire;
    sel_next  = sel_reg ^ swap_fire;
    pend_next = swap_fire ? 1'b0 : (pend_reg | bus.swap_req);
  end

  assign front = sel_reg ? buf1_reg : buf0_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LEDS_N; gi++) begin : g_row
      assign n_en_next[gi] = (state_next == ON) && (row_next == N_BITS'(gi));
    end

    for (gi = 0; gi < LEDS_M; gi++) begin : g_col
      logic [PWM_BITS-1:0] col_pix;
      always_comb begin
        col_pix = '0;
        for (int r = 0; r < LEDS_N; r++) begin
          if (row_next == N_BITS'(r)) begin
            col_pix = front[(r * LEDS_M + gi) * PWM_BITS +: PWM_BITS];
          end
        end
      end
      assign m_en_next[gi] = (state_next == ON) && (step_next < col_pix);
    end

    // Address decode compares against real pixel coordinates, so out-of-range
    // rows or columns simply match nothing.
    for (gi = 0; gi < NPIX; gi++) begin : g_pix
      assign wr_hit[gi] = bus.wr_en &&
                          (wr_row == N_BITS'(gi / LEDS_M)) &&
                          (wr_col == M_BITS'(gi % LEDS_M));
    end
  endgenerate

  assign wr_row = bus.wr_addr[N_BITS+M_BITS-1 -: N_BITS];
  assign wr_col = bus.wr_addr[M_BITS-1:0];

  // Writes target the buffer not currently shown, using the pre-swap select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf0_reg <= '0;
      buf1_reg <= '0;
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        if (wr_hit[i]) begin
          if (sel_reg) begin
            buf0_reg[i * PWM_BITS +: PWM_BITS] <= bus.wr_data;
          end else begin
            buf1_reg[i * PWM_BITS +: PWM_BITS] <= bus.wr_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      row_reg    <= '0;
      blank_reg  <= '0;
      step_reg   <= '0;
      tick_reg   <= '0;
      period_reg <= LED_PERIOD_BITS'(1);
      sel_reg    <= 1'b0;
      pend_reg   <= 1'b0;
      n_en_reg   <= '0;
      m_en_reg   <= '0;
      done_reg   <= 1'b0;
      ack_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      blank_reg  <= blank_next;
      step_reg   <= step_next;
      tick_reg   <= tick_next;
      period_reg <= period_next;
      sel_reg    <= sel_next;
      pend_reg   <= pend_next;
      n_en_reg   <= n_en_next;
      m_en_reg   <= m_en_next;
      done_reg   <= done_next;
      ack_reg    <= ack_next;
    end
  end

  assign n_en         = n_en_reg;
  assign m_en         = m_en_reg;
  assign done_tick    = done_reg;
  assign bus.swap_ack = ack_reg;

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Bench for led_matrix_pwm: frame-time arithmetic model checked every cycle,
// plus literal frame-length and lit-cycle counts for the directed scenarios.
module tb_led_matrix_pwm;

  localparam int B  = 2;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int S  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] led_period = 4'd2;
  logic [3:0] n_en;
  logic [3:0] m_en;
  logic       done_tick;

  led_matrix_pwm_if #(.N_BITS(3), .M_BITS(3), .PWM_BITS(2)) bus ();

  led_matrix_pwm #(
    .LEDS_N(4), .LEDS_M(4), .N_BITS(3), .M_BITS(3),
    .PWM_BITS(2), .LED_PERIOD_BITS(4), .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .led_period (led_period),
    .bus        (bus),
    .n_en       (n_en),
    .m_en       (m_en),
    .done_tick  (done_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int pix_m [2][16];
  int sel_m, pend_m, run_m, t_m, p_m;
  int cnt_full, cnt_nz, cnt_0100, cnt_ack;
  int n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) pix_m[b][i] = 0;
    sel_m = 0; pend_m = 0; run_m = 0; t_m = 0; p_m = 1;
  endtask

  task automatic clear_counts();
    cnt_full = 0; cnt_nz = 0; cnt_0100 = 0; cnt_ack = 0;
  endtask

  // One clock: advance the model on the edge, then compare the DUT 1ns later.
  task automatic cyc();
    int r, c, rowlen, row, off, s;
    logic [3:0] exp_n, exp_m;
    logic exp_d, exp_a;
    @(posedge clk);
    if (bus.wr_en === 1'b1) begin
      r = int'(bus.wr_addr[5:3]);
      c = int'(bus.wr_addr[2:0]);
      if (r < NR && c < NC) pix_m[1 - sel_m][r * NC + c] = int'(bus.wr_data);
    end
    exp_n = '0; exp_m = '0; exp_d = 1'b0; exp_a = 1'b0;
    if (!en) begin
      run_m = 0;
    end else if (run_m == 0) begin
      run_m = 1; t_m = 0;
      p_m = (led_period == 0) ? 1 : int'(led_period);
    end else begin
      t_m++;
      if (t_m == NR * (B + S * p_m)) begin
        t_m = 0;
        p_m = (led_period == 0) ? 1 : int'(led_period);
      end
    end
    if (run_m != 0) begin
      rowlen = B + S * p_m;
      row = t_m / rowlen;
      off = t_m % rowlen;
      if (off >= B) begin
        s = (off - B) / p_m;
        exp_n = 4'(1 << row);
        for (int cc = 0; cc < NC; cc++)
          if (s < pix_m[sel_m][row * NC + cc]) exp_m[cc] = 1'b1;
      end
      if (t_m == NR * rowlen - 1) begin
        exp_d = 1'b1;
        if (pend_m != 0 || bus.swap_req) begin
          exp_a = 1'b1;
          sel_m = 1 - sel_m;
          pend_m = 0;
        end
      end
    end
    if (!exp_a && bus.swap_req) pend_m = 1;
    #1;
    check("n_en", n_en, exp_n);
    check("m_en", m_en, exp_m);
    check("done_tick", done_tick, exp_d);
    check("swap_ack", bus.swap_ack, exp_a);
    if (m_en == 4'hF) cnt_full++;
    if (m_en != 4'h0) cnt_nz++;
    if (n_en == 4'b0010 && m_en == 4'b0100) cnt_0100++;
    if (bus.swap_ack === 1'b1) cnt_ack++;
  endtask

  task automatic wait_done(input int max, output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (done_tick !== 1'b1 && cycles < max);
    if (done_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done_tick within %0d cycles", max);
    end
  endtask

  task automatic write_pix(input logic [2:0] r, input logic [2:0] c, input logic [1:0] v);
    bus.wr_en = 1'b1;
    bus.wr_addr = {r, c};
    bus.wr_data = v;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
    model_reset();
    clear_counts();

    #12;
    check("rst_n_en", n_en, 4'h0);
    check("rst_m_en", m_en, 4'h0);
    check("rst_done", done_tick, 1'b0);
    check("rst_ack", bus.swap_ack, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // All pixels 3 in back buffer, swap requested while idle.
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) write_pix(3'(r), 3'(c), 2'd3);
    bus.swap_req = 1'b1; cyc(); bus.swap_req = 1'b0;
    led_period = 4'd2;
    en = 1'b1;
    wait_done(100, n);
    check("frame1_len", n, 32);
    check("frame1_ack", bus.swap_ack, 1'b1);
    clear_counts();
    wait_done(100, n);
    check("frame2_len", n, 32);
    check("frame2_full_cycles", cnt_full, 24);
    check("frame2_acks", cnt_ack, 0);

    // Single pixel (1,2)=1 into the other buffer, swap requested mid-frame.
    clear_counts();
    write_pix(3'd1, 3'd2, 2'd1);
    repeat (3) cyc();
    bus.swap_req = 1'b1; cyc(); bus.swap_req = 1'b0;
    wait_done(100, n);
    check("frame3_len", n, 27);
    check("frame3_ack_at_done", bus.swap_ack, 1'b1);
    check("frame3_acks", cnt_ack, 1);
    clear_counts();
    wait_done(100, n);
    check("frame4_len", n, 32);
    check("pix12_cycles", cnt_0100, 2);
    check("pix12_lit_cycles", cnt_nz, 2);

    // Write to back without a swap: display unchanged for three frames.
    clear_counts();
    write_pix(3'd0, 3'd0, 2'd0);
    repeat (3) wait_done(100, n);
    check("noswap_lit_cycles", cnt_nz, 6);
    check("noswap_acks", cnt_ack, 0);

    // led_period to 0 mid-frame: this frame keeps P=2, the next uses P=1.
    repeat (5) cyc();
    led_period = 4'd0;
    wait_done(100, n);
    check("period_change_rest", n, 27);
    wait_done(100, n);
    check("period0_frame_len", n, 20);

    // Out-of-range writes must not alias onto real pixels.
    write_pix(3'd5, 3'd0, 2'd0);
    write_pix(3'd0, 3'd6, 2'd0);
    bus.swap_req = 1'b1; cyc(); bus.swap_req = 1'b0;
    wait_done(100, n);
    clear_counts();
    wait_done(100, n);
    check("oor_frame_len", n, 20);
    check("oor_lit_cycles", cnt_nz, 12);
    check("oor_full_cycles", cnt_full, 9);

    // en dropped mid-row with a swap pending; the swap survives the restart.
    repeat (7) cyc();
    bus.swap_req = 1'b1; cyc(); bus.swap_req = 1'b0;
    en = 1'b0;
    cyc();
    check("en_off_n_en", n_en, 4'h0);
    check("en_off_m_en", m_en, 4'h0);
    repeat (3) cyc();
    en = 1'b1;
    wait_done(100, n);
    check("restart_frame_len", n, 20);
    check("restart_ack", bus.swap_ack, 1'b1);

    // Asynchronous reset mid-frame while pixel (1,2) is lit.
    repeat (8) cyc();
    check("pre_reset_m_en", m_en, 4'b0100);
    #2 reset = 1'b0;
    #1;
    check("midrst_n_en", n_en, 4'h0);
    check("midrst_m_en", m_en, 4'h0);
    check("midrst_done", done_tick, 1'b0);
    check("midrst_ack", bus.swap_ack, 1'b0);
    model_reset();
    #2 reset = 1'b1;
    clear_counts();
    wait_done(100, n);
    check("post_reset_frame_len", n, 20);
    check("post_reset_lit_cycles", cnt_nz, 0);
    check("post_reset_ack", bus.swap_ack, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
